// File: rtl/rotary_pos_if.sv
// Bundle between the rotary detector side and the position controller.
// Level semantics, no valid/ready: r_event is a level whose 0->1 edges are detents; step_pulse is a 1-cycle strobe.
interface rotary_pos_if #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH)
);
  logic             r_event;
  logic             r_direction;
  logic             enable;
  logic             mode;
  logic [PW-1:0]    pos;
  logic [WIDTH-1:0] led;
  logic             step_pulse;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output r_event, r_direction, enable, mode,
    input  pos, led, step_pulse, busy, dbg_state
  );

  modport slave (
    input  r_event, r_direction, enable, mode,
    output pos, led, step_pulse, busy, dbg_state
  );
endinterface

// File: rtl/rotary_pos_ctrl.sv
// Rotary detent to position counter with hold-off lock-out and LED pattern output.
// Define ROTARY_SATURATE_EN to saturate pos at 0 / WIDTH-1 instead of wrapping.
module rotary_pos_ctrl #(
  parameter int WIDTH   = 8,
  parameter int HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        rst,
  rotary_pos_if.slave bus
);
  localparam int PW = $clog2(WIDTH);
  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, HOLD = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_pos, w_pos_nxt, w_pos_stepped;
  logic            r_dir, w_dir_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_step, w_step_nxt;
  logic            r_event_q;
  logic            w_rise;
  logic            w_at_limit;
  logic [WIDTH-1:0] w_led;

  assign w_rise = bus.r_event & ~r_event_q;

  // r_event_q resets high so a level already present at release is not a detent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pos     <= '0;
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_step    <= 1'b0;
      r_event_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_cnt     <= w_cnt_nxt;
      r_step    <= w_step_nxt;
      r_event_q <= bus.r_event;
    end
  end

  always_comb begin
    w_at_limit    = 1'b0;
    w_pos_stepped = r_pos;
    if (!r_dir) begin
      w_at_limit    = (r_pos == PW'(WIDTH - 1));
      w_pos_stepped = w_at_limit ? '0 : r_pos + PW'(1);
    end else begin
      w_at_limit    = (r_pos == '0);
      w_pos_stepped = w_at_limit ? PW'(WIDTH - 1) : r_pos - PW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && bus.enable) begin
          w_dir_nxt   = bus.r_direction;
          w_state_nxt = STEP;
        end
      end
      STEP: begin
`ifdef ROTARY_SATURATE_EN
        if (!w_at_limit) begin
          w_pos_nxt  = w_pos_stepped;
          w_step_nxt = 1'b1;
        end
`else
        w_pos_nxt  = w_pos_stepped;
        w_step_nxt = 1'b1;
`endif
        w_cnt_nxt   = CW'(HOLDOFF - 1);
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // mode 0 lights only bit pos; mode 1 lights bits pos..0
  always_comb begin
    w_led = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.mode) w_led[i] = (i <= int'(r_pos));
      else          w_led[i] = (i == int'(r_pos));
    end
  end

  assign bus.pos        = r_pos;
  assign bus.led        = w_led;
  assign bus.step_pulse = r_step;
  assign bus.busy       = (r_state != IDLE);
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_rotary_pos_ctrl.sv
// Directed bench for rotary_pos_ctrl (WIDTH=8, HOLDOFF=4): step table plus hand-written timing sequences.
module tb_rotary_pos_ctrl;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q[$];

  rotary_pos_if #(.WIDTH(8)) bus ();

  rotary_pos_ctrl #(.WIDTH(8), .HOLDOFF(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic       en;
    logic       mode;
    logic [2:0] exp_pos;
    logic [7:0] exp_led;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full detent: raise r_event, count strobes until the FSM is idle again, then drop it.
  task automatic detent(input logic dir, input logic en, output int pulses);
    @(negedge clk);
    bus.r_direction = dir;
    bus.enable      = en;
    bus.r_event     = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.step_pulse) pulses++;
    end
    bus.r_event = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p;
    logic [2:0] p0;

    rst             = 1'b1;
    bus.r_event     = 1'b1;
    bus.r_direction = 1'b0;
    bus.enable      = 1'b1;
    bus.mode        = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 3'd1, 8'h02, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 3'd2, 8'h07, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 3'd1, 8'h02, 1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1};
`ifdef ROTARY_SATURATE_EN
    vecs[4] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h01, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 3'd1, 8'h03, 1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 3'd2, 8'h04, 1};
`else
    vecs[4] = '{1'b1, 1'b1, 1'b0, 3'd7, 8'h80, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 3'd6, 8'h7f, 1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd6, 8'h40, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 3'd7, 8'hff, 1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 1};
`endif
    foreach (vecs[i]) exp_q.push_back({29'd0, vecs[i].exp_pos});

    // Reset released with r_event already high: no step
    do_reset();
    check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    p = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.step_pulse) p++;
    end
    check("rst_hi_pulses", p, 0);
    check("rst_hi_pos", {29'd0, bus.pos}, 32'd0);
    check("rst_hi_led", {24'd0, bus.led}, 32'h01);
    check("rst_hi_busy", {31'd0, bus.busy}, 32'd0);
    bus.r_event = 1'b0;
    repeat (2) @(negedge clk);

    // Latency and busy window of a single step
    bus.r_event = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check($sformatf("lat_busy_%0d", n), {31'd0, bus.busy}, (n <= 5) ? 32'd1 : 32'd0);
      check($sformatf("lat_pulse_%0d", n), {31'd0, bus.step_pulse}, (n == 2) ? 32'd1 : 32'd0);
      if (n == 1) check("lat_state_step", {30'd0, bus.dbg_state}, 32'd1);
      if (n == 1) check("lat_pos_old", {29'd0, bus.pos}, 32'd0);
    end
    check("lat_pos", {29'd0, bus.pos}, 32'd1);
    check("lat_led", {24'd0, bus.led}, 32'h02);
    bus.r_event = 1'b0;
    repeat (2) @(negedge clk);

    // Step table from pos 0
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.mode = vecs[i].mode;
      detent(vecs[i].dir, vecs[i].en, p);
      check($sformatf("vec%0d_pos", i), {29'd0, bus.pos}, exp_q.pop_front());
      check($sformatf("vec%0d_led", i), {24'd0, bus.led}, {24'd0, vecs[i].exp_led});
      check($sformatf("vec%0d_pulses", i), p, vecs[i].exp_pulses);
    end
    bus.enable = 1'b1;
    bus.mode   = 1'b0;

    // Second rise during HOLD is dropped, held level does not retrigger
    do_reset();
    @(negedge clk);
    bus.r_direction = 1'b0;
    bus.r_event     = 1'b1;
    p = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.step_pulse) p++;
      if (n == 1) bus.r_event = 1'b0;
      if (n == 2) bus.r_event = 1'b1;
    end
    check("hold_rise_pulses", p, 1);
    check("hold_rise_pos", {29'd0, bus.pos}, 32'd1);
    bus.r_event = 1'b0;
    repeat (2) @(negedge clk);

    // enable dropped right after an accepted rise still completes the step
    p0 = bus.pos;
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.r_event = 1'b1;
    p = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) bus.enable = 1'b0;
      if (bus.step_pulse) p++;
    end
    check("en_drop_pulses", p, 1);
    check("en_drop_pos", {29'd0, bus.pos}, {29'd0, p0 + 3'd1});
    bus.r_event = 1'b0;
    bus.enable  = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during HOLD with pos=3
    do_reset();
    detent(1'b0, 1'b1, p);
    detent(1'b0, 1'b1, p);
    @(negedge clk);
    bus.r_event = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_hold_busy", {31'd0, bus.busy}, 32'd1);
    check("mid_hold_pos", {29'd0, bus.pos}, 32'd3);
    rst = 1'b1;
    #1;
    check("rst_hold_pos", {29'd0, bus.pos}, 32'd0);
    check("rst_hold_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_hold_led", {24'd0, bus.led}, 32'h01);
    @(negedge clk);
    rst = 1'b0;
    bus.r_event = 1'b0;
    @(negedge clk);
    detent(1'b0, 1'b1, p);
    check("post_rst_pulses", p, 1);
    check("post_rst_pos", {29'd0, bus.pos}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
